modadd_rr_scheduler: RTL and testbench

MODADD_RR_SCHEDULER -- requirements
Module: modadd_rr_scheduler

---
 rtl/modadd_rr_scheduler.sv | 102 ++++++++++
 tb/tb_modadd_rr_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/modadd_rr_scheduler.sv
// Round-robin arbiter feeding a two-stage (x + y) mod M pipeline.
// Stage 1 holds the granted operands; stage 2 holds the reduced result.
module modadd_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter logic [255:0] MOD =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*256-1:0] req_x,
  input  logic [NREQ*256-1:0] req_y,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  output logic [255:0]        out_z,
  output logic [IDW-1:0]      out_id,
  input  logic                out_ready
);

  logic           v1, v2;
  logic [255:0]   x1, y1;
  logic [IDW-1:0] id1;
  logic [255:0]   z2;
  logic [IDW-1:0] id2;
  logic [IDW-1:0] rr_ptr;

  logic           adv1, adv2;
  logic           found;
  logic [IDW-1:0] gnt_id;
  int unsigned    idx;

  logic [256:0]   sum;
  logic [255:0]   diff;
  logic           sub_sel;
  logic [255:0]   z_next;

  assign adv2 = !v2 || out_ready;
  assign adv1 = !v1 || adv2;

  // Grants are suppressed while rst is high so nothing looks accepted
  // in a cycle whose edge is about to clear the pipeline.
  always_comb begin
    found     = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    req_ready = '0;
    if (adv1 && !rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(rr_ptr) + k) % NREQ;
        if (!found && req_valid[IDW'(idx)]) begin
          found  = 1'b1;
          gnt_id = IDW'(idx);
        end
      end
      if (found) req_ready[gnt_id] = 1'b1;
    end
  end

  // Carry out of bit 255 means the true sum is already >= 2^256 > M.
  always_comb begin
    sum     = {1'b0, x1} + {1'b0, y1};
    diff    = sum[255:0] - MOD;
    sub_sel = sum[256] || (sum[255:0] >= MOD);
    z_next  = sub_sel ? diff : sum[255:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      x1     <= '0;
      y1     <= '0;
      id1    <= '0;
      z2     <= '0;
      id2    <= '0;
      rr_ptr <= '0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          z2  <= z_next;
          id2 <= id1;
        end
      end
      if (adv1) begin
        v1 <= found;
        if (found) begin
          x1     <= req_x[32'(gnt_id)*256 +: 256];
          y1     <= req_y[32'(gnt_id)*256 +: 256];
          id1    <= gnt_id;
          rr_ptr <= IDW'((32'(gnt_id) + 1) % NREQ);
        end
      end
    end
  end

  assign out_valid = v2;
  assign out_z     = z2;
  assign out_id    = id2;

endmodule

// File: tb/tb_modadd_rr_scheduler.sv
// Directed bench for modadd_rr_scheduler: vector table plus hand-written
// sequences for fairness, backpressure, mid-stream reset and wrap search.
module tb_modadd_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [255:0] M =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*256-1:0] req_x;
  logic [NREQ*256-1:0] req_y;
  logic [NREQ-1:0]     req_ready;
  logic                out_valid;
  logic [255:0]        out_z;
  logic [IDW-1:0]      out_id;
  logic                out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  modadd_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .MOD(M)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .out_valid(out_valid), .out_z(out_z), .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [255:0]   x;
    logic [255:0]   y;
    logic [255:0]   z;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Requester i presents x = i+1, y = 100, so its result is i+101.
  task automatic load_fixed_operands();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*256 +: 256] = 256'(i + 1);
      req_y[i*256 +: 256] = 256'd100;
    end
  endtask

  initial begin
    vt[0] = '{2'd0, 256'd5, 256'd7, 256'd12};
    vt[1] = '{2'd1, M - 256'd1, 256'd1, 256'd0};
    vt[2] = '{2'd3, M - 256'd1, M - 256'd1, M - 256'd2};
    vt[3] = '{2'd0, 256'd1 << 255, 256'd1 << 255, 256'd0 - M};
    vt[4] = '{2'd1, M - 256'd1, 256'd0, M - 256'd1};
    vt[5] = '{2'd3, 256'd123456789, 256'd987654321, 256'd1111111110};
    vt[6] = '{2'd2, 256'd0, 256'd0, 256'd0};
    vt[7] = '{2'd2, 256'd10, 256'd20, 256'd30};

    rst       = 1'b1;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    out_ready = 1'b1;

    // Reset state
    #1;
    tick();
    check("rst_req_ready", 256'(req_ready), 256'd0);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_out_z", out_z, 256'd0);
    check("rst_out_id", 256'(out_id), 256'd0);
    rst       = 1'b0;
    req_valid = '0;
    tick();

    // Single-requester vectors: grant, then result two cycles later
    for (int v = 0; v < 8; v++) begin
      req_valid              = '0;
      req_valid[vt[v].id]    = 1'b1;
      req_x[vt[v].id*256 +: 256] = vt[v].x;
      req_y[vt[v].id*256 +: 256] = vt[v].y;
      #1;
      check($sformatf("vec%0d_ready", v), 256'(req_ready), 256'(4'b0001 << vt[v].id));
      tick();
      req_valid = '0;
      check($sformatf("vec%0d_t1_valid", v), 256'(out_valid), 256'd0);
      tick();
      check($sformatf("vec%0d_valid", v), 256'(out_valid), 256'd1);
      check($sformatf("vec%0d_z", v), out_z, vt[v].z);
      check($sformatf("vec%0d_id", v), 256'(out_id), 256'(vt[v].id));
    end

    // Two grants to requester 2 leave rr_ptr at 3: all-valid must pick 3
    load_fixed_operands();
    req_valid = '1;
    #1;
    check("sparse_ptr3_ready", 256'(req_ready), 256'b1000);
    tick();
    req_valid = '0;
    tick();
    check("sparse_out_id", 256'(out_id), 256'd3);
    check("sparse_out_z", out_z, 256'd104);
    tick();

    // Fairness from rr_ptr = 0
    do_reset();
    load_fixed_operands();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("fair%0d_ready", k), 256'(req_ready), 256'(4'b0001 << (k % 4)));
      tick();
      check($sformatf("fair%0d_valid", k), 256'(out_valid), 256'(k >= 1));
      if (k >= 1) begin
        check($sformatf("fair%0d_id", k), 256'(out_id), 256'((k - 1) % 4));
        check($sformatf("fair%0d_z", k), out_z, 256'(((k - 1) % 4) + 101));
      end
    end
    req_valid = '0;
    #1;
    check("fair_idle_ready", 256'(req_ready), 256'd0);
    tick();
    check("fair_last_id", 256'(out_id), 256'd3);
    check("fair_last_z", out_z, 256'd104);
    tick();
    check("fair_drained", 256'(out_valid), 256'd0);

    // Backpressure: S2 and S1 fill, then grants stop until out_ready returns
    do_reset();
    load_fixed_operands();
    out_ready = 1'b0;
    req_valid = '1;
    #1;
    check("bp_grant0", 256'(req_ready), 256'b0001);
    tick();
    check("bp_c1_valid", 256'(out_valid), 256'd0);
    check("bp_grant1", 256'(req_ready), 256'b0010);
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d_valid", c), 256'(out_valid), 256'd1);
      check($sformatf("bp_hold%0d_id", c), 256'(out_id), 256'd0);
      check($sformatf("bp_hold%0d_z", c), out_z, 256'd101);
      check($sformatf("bp_hold%0d_ready", c), 256'(req_ready), 256'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_grant", 256'(req_ready), 256'b0100);
    tick();
    req_valid = '0;
    check("bp_drain1_id", 256'(out_id), 256'd1);
    check("bp_drain1_z", out_z, 256'd102);
    tick();
    check("bp_drain2_id", 256'(out_id), 256'd2);
    check("bp_drain2_z", out_z, 256'd103);
    tick();
    check("bp_drained", 256'(out_valid), 256'd0);

    // Reset mid-stream with both stages occupied (rr_ptr is 3 here)
    req_valid = '1;
    #1;
    check("mid_grant3", 256'(req_ready), 256'b1000);
    tick();
    check("mid_grant0", 256'(req_ready), 256'b0001);
    tick();
    check("mid_v2_full", 256'(out_valid), 256'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 256'(req_ready), 256'd0);
    tick();
    rst       = 1'b0;
    req_valid = 4'b1110;
    #1;
    check("mid_after_rst_valid", 256'(out_valid), 256'd0);
    check("mid_after_rst_grant", 256'(req_ready), 256'b0010);
    tick();
    req_valid = '0;
    check("mid_no_stale", 256'(out_valid), 256'd0);
    tick();
    check("mid_new_valid", 256'(out_valid), 256'd1);
    check("mid_new_id", 256'(out_id), 256'd1);
    check("mid_new_z", out_z, 256'd102);
    tick();
    check("mid_drained", 256'(out_valid), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
